// File: rtl/scratch_stack_mem.sv
// rtl/scratch_stack_mem.sv - scratch RAM with stack pointer unit, hardware clear after reset.
// Optional stored even parity per word when SCR_PARITY_EN is defined.
module scratch_stack_mem #(
   parameter int                DATA_W  = 10,
   parameter int                ADDR_W  = 8,
   parameter logic [ADDR_W-1:0] SP_INIT = '0
) (
   input  logic              SCR_CLK,
   input  logic              SCR_RST,
   input  logic [ADDR_W-1:0] SCR_ADDR,
   input  logic [DATA_W-1:0] SCR_DIN,
   input  logic              SCR_WE,
   input  logic              SCR_PUSH,
   input  logic              SCR_POP,
   output logic [DATA_W-1:0] SCR_DOUT,
   output logic [ADDR_W-1:0] SP_OUT,
   output logic              SCR_BUSY,
   output logic              SCR_OVF,
   output logic              SCR_UNF,
   output logic              SCR_PERR
);

   localparam int DEPTH = 1 << ADDR_W;
`ifdef SCR_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif
   localparam logic [ADDR_W-1:0] ONE_A      = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   ONE_C      = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic [ADDR_W-1:0]   sp_q, sp_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic [WORD_W-1:0]   mem [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [WORD_W-1:0]   mem_wdata;

   logic                busy;
   logic [ADDR_W-1:0]   rd_addr;
   logic [WORD_W-1:0]   rd_word;

   function automatic logic [WORD_W-1:0] encode_word(input logic [DATA_W-1:0] data);
`ifdef SCR_PARITY_EN
      return {^data, data};
`else
      return data;
`endif
   endfunction

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      sp_d      = sp_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      mem_we    = 1'b0;
      mem_waddr = SCR_ADDR;
      mem_wdata = encode_word(SCR_DIN);

      if (state_q == ST_CLEAR) begin
         // Clearing owns the write port; any request this cycle is dropped.
         mem_we    = 1'b1;
         mem_waddr = clr_ptr_q;
         mem_wdata = '0;
         clr_ptr_d = clr_ptr_q + ONE_A;
         if (clr_ptr_q == '1) begin
            state_d = ST_RUN;
         end
      end else if (SCR_PUSH && SCR_POP) begin
         state_d = ST_RUN;
      end else if (SCR_PUSH) begin
         if (count_q != COUNT_FULL) begin
            mem_we    = 1'b1;
            mem_waddr = sp_q - ONE_A;
            sp_d      = sp_q - ONE_A;
            count_d   = count_q + ONE_C;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (SCR_POP) begin
         if (count_q != '0) begin
            sp_d    = sp_q + ONE_A;
            count_d = count_q - ONE_C;
         end else begin
            unf_d = 1'b1;
         end
      end else if (SCR_WE) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge SCR_CLK) begin
      if (SCR_RST) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
         sp_q      <= SP_INIT;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         sp_q      <= sp_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   always_ff @(posedge SCR_CLK) begin
      if (mem_we && !SCR_RST) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign busy     = SCR_RST || (state_q == ST_CLEAR);
   assign rd_addr  = SCR_POP ? sp_q : SCR_ADDR;
   assign rd_word  = mem[rd_addr];

   assign SCR_DOUT = busy ? '0 : rd_word[DATA_W-1:0];
   assign SP_OUT   = sp_q;
   assign SCR_BUSY = busy;
   assign SCR_OVF  = ovf_q;
   assign SCR_UNF  = unf_q;
`ifdef SCR_PARITY_EN
   assign SCR_PERR = busy ? 1'b0 : ^rd_word;
`else
   assign SCR_PERR = 1'b0;
`endif

endmodule

// File: tb/tb_scratch_stack_mem.sv
// tb/tb_scratch_stack_mem.sv - self-checking bench for scratch_stack_mem against a behavioural model.
// Parity checks are included when SCR_PARITY_EN is defined.
module tb_scratch_stack_mem;
   localparam int DW = 10;
   localparam int AW = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] din = '0;
   logic          we = 1'b0, push = 1'b0, pop = 1'b0;
   logic [DW-1:0] dout;
   logic [AW-1:0] sp_out;
   logic          busy, ovf, unf, perr;

   int n_checks = 0;
   int n_fail = 0;

   logic [DW-1:0] m_mem [DEPTH];
   int            m_sp, m_cnt;
   logic          m_ovf, m_unf;

   always #5 clk = ~clk;

   scratch_stack_mem #(.DATA_W(DW), .ADDR_W(AW), .SP_INIT(8'h00)) dut (
      .SCR_CLK(clk), .SCR_RST(rst), .SCR_ADDR(addr), .SCR_DIN(din),
      .SCR_WE(we), .SCR_PUSH(push), .SCR_POP(pop), .SCR_DOUT(dout),
      .SP_OUT(sp_out), .SCR_BUSY(busy), .SCR_OVF(ovf), .SCR_UNF(unf), .SCR_PERR(perr)
   );

   task automatic set_in(input logic w, input logic pu, input logic po,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      we = w; push = pu; pop = po; addr = a; din = d;
   endtask

   function automatic logic [DW-1:0] m_read();
      return pop ? m_mem[m_sp] : m_mem[addr];
   endfunction

   // Applies the current inputs to the model as one RUN-state clock edge.
   task automatic model_step();
      if (push && pop) begin
      end else if (push) begin
         if (m_cnt < DEPTH) begin
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            m_mem[m_sp] = din;
            m_cnt++;
         end else m_ovf = 1'b1;
      end else if (pop) begin
         if (m_cnt > 0) begin
            m_sp = (m_sp + 1) % DEPTH;
            m_cnt--;
         end else m_unf = 1'b1;
      end else if (we) begin
         m_mem[addr] = din;
      end
   endtask

   task automatic model_reset();
      foreach (m_mem[i]) m_mem[i] = '0;
      m_sp = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic test_reset();
      int n, bad;
      @(negedge clk);
      set_in(0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_reset act=%b exp=1", busy); end
      n_checks++; if (sp_out !== 8'h00) begin n_fail++; $display("FAIL sp_reset act=%h exp=00", sp_out); end
      rst = 1'b0;
      model_reset();
      set_in(1, 0, 0, 8'h10, 10'h3FF);
      n = 0; bad = 0;
      #1;
      while (busy && n < 1000) begin
         pop = n[0];
         #1;
         if (dout !== '0 || perr !== 1'b0) bad++;
         n++;
         @(negedge clk);
      end
      set_in(0, 0, 0, 0, 0);
      n_checks++; if (n !== 256) begin n_fail++; $display("FAIL busy_cycles act=%0d exp=256", n); end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL dout_while_busy act=%0d nonzero exp=0", bad); end
      n_checks++; if (sp_out !== 8'h00 || unf !== 1'b0 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL post_clear_state act=sp %h ovf %b unf %b exp=sp 00 ovf 0 unf 0", sp_out, ovf, unf);
      end
      foreach (addr_list[i]) begin
         addr = addr_list[i];
         #1;
         n_checks++; if (dout !== 10'h000) begin n_fail++; $display("FAIL clear_read addr=%h act=%h exp=000", addr, dout); end
      end
   endtask

   logic [AW-1:0] addr_list [4] = '{8'h00, 8'h7F, 8'hFF, 8'h10};

   task automatic test_random_write();
      @(negedge clk);
      set_in(1, 0, 0, 8'h10, 10'h2AB);
      #1;
      n_checks++; if (dout !== 10'h000) begin n_fail++; $display("FAIL write_before_edge act=%h exp=000", dout); end
      model_step();
      @(negedge clk);
      set_in(0, 0, 0, 8'h10, 10'h000);
      #1;
      n_checks++; if (dout !== 10'h2AB) begin n_fail++; $display("FAIL write_readback act=%h exp=2ab", dout); end
   endtask

   task automatic test_push_pop();
      logic [AW-1:0] exp_sp [4] = '{8'hFF, 8'hFE, 8'hFF, 8'h00};
      logic [DW-1:0] vals [2] = '{10'h155, 10'h0AA};
      logic [DW-1:0] exp_pop [2] = '{10'h0AA, 10'h155};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 2) set_in(0, 1, 0, 0, vals[i]);
         else set_in(0, 0, 1, 0, 0);
         #1;
         if (i >= 2) begin
            n_checks++; if (dout !== exp_pop[i-2]) begin n_fail++; $display("FAIL pop_data %0d act=%h exp=%h", i-2, dout, exp_pop[i-2]); end
         end
         model_step();
         @(negedge clk);
         set_in(0, 0, 0, 8'hFF, 0);
         #1;
         n_checks++; if (sp_out !== exp_sp[i]) begin n_fail++; $display("FAIL push_pop_sp %0d act=%h exp=%h", i, sp_out, exp_sp[i]); end
         if (i == 0) begin
            n_checks++; if (dout !== 10'h155) begin n_fail++; $display("FAIL mem_ff act=%h exp=155", dout); end
         end
      end
   endtask

   task automatic test_boundaries();
      logic [AW-1:0] a;
      @(negedge clk);
      set_in(0, 0, 1, 0, 0);
      #1;
      n_checks++; if (dout !== m_read()) begin n_fail++; $display("FAIL unf_pop_dout act=%h exp=%h", dout, m_read()); end
      model_step();
      @(negedge clk);
      n_checks++; if (unf !== 1'b1 || sp_out !== 8'(m_sp)) begin
         n_fail++; $display("FAIL underflow act=unf %b sp %h exp=unf 1 sp %h", unf, sp_out, 8'(m_sp));
      end
      for (int i = 0; i < DEPTH; i++) begin
         set_in(0, 1, 0, 0, 10'($urandom));
         model_step();
         @(negedge clk);
      end
      n_checks++; if (ovf !== 1'b0 || sp_out !== 8'h00) begin
         n_fail++; $display("FAIL full_stack act=ovf %b sp %h exp=ovf 0 sp 00", ovf, sp_out);
      end
      set_in(0, 1, 0, 0, 10'h3FF);
      model_step();
      @(negedge clk);
      set_in(0, 0, 0, 0, 0);
      n_checks++; if (ovf !== 1'b1 || sp_out !== 8'h00) begin
         n_fail++; $display("FAIL overflow act=ovf %b sp %h exp=ovf 1 sp 00", ovf, sp_out);
      end
      for (int i = 0; i < 8; i++) begin
         a = (i == 0) ? 8'hFF : 8'($urandom);
         addr = a;
         #1;
         n_checks++; if (dout !== m_mem[a]) begin n_fail++; $display("FAIL ovf_mem addr=%h act=%h exp=%h", a, dout, m_mem[a]); end
      end
      @(negedge clk);
      set_in(1, 1, 1, 8'h33, 10'h111);
      model_step();
      @(negedge clk);
      set_in(0, 0, 0, 8'h33, 0);
      #1;
      n_checks++; if (sp_out !== 8'(m_sp) || dout !== m_mem[8'h33]) begin
         n_fail++; $display("FAIL push_and_pop act=sp %h mem33 %h exp=sp %h mem33 %h", sp_out, dout, 8'(m_sp), m_mem[8'h33]);
      end
   endtask

   task automatic test_random_ops();
      int r;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         r = $urandom_range(0, 9);
         set_in(1'($urandom), r == 0 || (r >= 1 && r <= 3), r == 0 || (r >= 4 && r <= 6),
                8'($urandom), 10'($urandom));
         if (r >= 7) begin push = 1'b0; pop = 1'b0; we = (r != 9); end
         #1;
         exp_d = m_read();
         n_checks++; if (dout !== exp_d) begin n_fail++; $display("FAIL rand_dout cyc=%0d act=%h exp=%h", i, dout, exp_d); end
         model_step();
         @(posedge clk);
         #1;
         n_checks++; if (sp_out !== 8'(m_sp) || ovf !== m_ovf || unf !== m_unf) begin
            n_fail++; $display("FAIL rand_state cyc=%0d act=sp %h ovf %b unf %b exp=sp %h ovf %b unf %b",
                               i, sp_out, ovf, unf, 8'(m_sp), m_ovf, m_unf);
         end
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0);
   endtask

   task automatic test_mid_clear_reset();
      int n;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin
         n_fail++; $display("FAIL mid_clear_reset act=busy %b ovf %b unf %b exp=busy 1 ovf 0 unf 0", busy, ovf, unf);
      end
      rst = 1'b0;
      model_reset();
      #1;
      n = 0;
      while (busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
      n_checks++; if (n !== 256) begin n_fail++; $display("FAIL busy_after_restart act=%0d exp=256", n); end
   endtask

`ifdef SCR_PARITY_EN
   task automatic test_parity();
      @(negedge clk);
      set_in(1, 0, 0, 8'h20, 10'h001);
      @(negedge clk);
      set_in(0, 0, 0, 8'h20, 0);
      #1;
      n_checks++; if (perr !== 1'b0 || dout !== 10'h001) begin n_fail++; $display("FAIL parity_clean act=%b exp=0", perr); end
      dut.mem[8'h20][DW] = ~dut.mem[8'h20][DW];
      #1;
      n_checks++; if (perr !== 1'b1) begin n_fail++; $display("FAIL parity_flip act=%b exp=1", perr); end
      addr = 8'h21;
      #1;
      n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL parity_other act=%b exp=0", perr); end
   endtask
`endif

   initial begin
      test_reset();
      test_random_write();
      test_push_pop();
      test_boundaries();
      test_random_ops();
      test_mid_clear_reset();
`ifdef SCR_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
